// File: rtl/sha256_pkg.sv
// Shared types, widths and the last-word padding helper for the SHA-256 message padder.
package sha256_pkg;

  typedef enum logic {
    ACCUM,
    HOLD
  } pad_state_e;

  localparam int SHA256_BLOCK_W     = 512;
  localparam int SHA256_WORD_W      = 32;
  localparam int SHA256_LEN_FIELD_W = 64;

  localparam logic [7:0] PAD_MARKER = 8'h80;

  // Keeps the first nbytes of a big-endian word, drops the 0x80 marker right after them
  // and zeroes the rest; a full word passes through untouched (its marker lands in the next word).
  function automatic logic [SHA256_WORD_W-1:0] pad_last_word(
    input logic [SHA256_WORD_W-1:0] data,
    input logic [2:0]               nbytes
  );
    case (nbytes)
      3'd1:    pad_last_word = {data[31:24], PAD_MARKER, 16'h0000};
      3'd2:    pad_last_word = {data[31:16], PAD_MARKER, 8'h00};
      3'd3:    pad_last_word = {data[31:8], PAD_MARKER};
      default: pad_last_word = data;
    endcase
  endfunction

endpackage

// File: rtl/sha256_len_ctr.sv
// Message bit-length accumulator: adds 8*nbytes per accepted word and wraps silently at 2^LEN_W.
module sha256_len_ctr #(
  parameter int LEN_W = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             add,
  input  logic [2:0]       nbytes,
  output logic [LEN_W-1:0] len,
  output logic [LEN_W-1:0] len_sum
);

  logic [LEN_W-1:0] len_q;

  // len_sum already includes the word being accepted, so the padder can write it in the same cycle.
  assign len_sum = len_q + LEN_W'({nbytes, 3'b000});
  assign len     = len_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q <= '0;
    end else if (clear) begin
      len_q <= '0;
    end else if (add) begin
      len_q <= len_sum;
    end
  end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 padder: packs 32-bit message words into 512-bit blocks with 0x80 marker and 64-bit length.
// Optional SHA256_PADDER_ERR_EN adds a sticky err output for out-of-range in_bytes.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SHA256_WORD_W-1:0]  in_data,
  input  logic                      in_last,
  input  logic [2:0]                in_bytes,
  output logic                      blk_valid,
  input  logic                      blk_ready,
  output logic [SHA256_BLOCK_W-1:0] blk_data,
  output logic                      blk_first,
  output logic                      blk_last
`ifdef SHA256_PADDER_ERR_EN
  ,
  output logic                      err
`endif
);

  pad_state_e state, state_d;

  logic [3:0]                    idx;
  logic                          rdy_en;
  logic                          mid_msg;
  logic                          pend_extra;
  logic                          extra_marker;
  logic                          first_q;
  logic                          last_q;
  logic [SHA256_BLOCK_W-1:0]     blk_q;
  logic [SHA256_BLOCK_W-1:0]     blk_d;
  logic                          xfer_in;
  logic                          xfer_blk;
  logic [2:0]                    nb;
  logic [4:0]                    marker_idx;
  logic                          blk_done;
  logic [LEN_W-1:0]              len_q;
  logic [LEN_W-1:0]              len_sum;
  logic [SHA256_LEN_FIELD_W-1:0] len_fld_sum;
  logic [SHA256_LEN_FIELD_W-1:0] len_fld_q;

`ifdef SHA256_PADDER_ERR_EN
  logic bad_bytes;

  assign bad_bytes = (in_bytes == 3'd0) || (in_bytes > 3'd4);
  assign nb        = bad_bytes ? 3'd4 : in_bytes;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else if (xfer_in && in_last && bad_bytes) begin
      err <= 1'b1;
    end
  end
`else
  assign nb = in_bytes;
`endif

  // rdy_en holds in_ready low for the first cycle after reset release.
  assign in_ready  = rdy_en && (state == ACCUM);
  assign blk_valid = (state == HOLD);
  assign blk_data  = blk_q;
  assign blk_first = first_q;
  assign blk_last  = last_q;

  assign xfer_in    = in_valid && in_ready;
  assign xfer_blk   = blk_valid && blk_ready;
  assign blk_done   = xfer_in && (in_last || idx == 4'd15);
  assign marker_idx = {1'b0, idx} + ((nb == 3'd4) ? 5'd1 : 5'd0);

  sha256_len_ctr #(
    .LEN_W (LEN_W)
  ) u_len_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (xfer_blk && !pend_extra && last_q),
    .add     (xfer_in),
    .nbytes  (in_last ? nb : 3'd4),
    .len     (len_q),
    .len_sum (len_sum)
  );

  always_comb begin
    len_fld_sum              = '0;
    len_fld_sum[LEN_W-1:0]   = len_sum;
    len_fld_q                = '0;
    len_fld_q[LEN_W-1:0]     = len_q;
  end

  always_comb begin
    state_d = state;
    case (state)
      ACCUM:   if (blk_done) state_d = HOLD;
      HOLD:    if (xfer_blk && !pend_extra) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // A last word pads the whole remainder of the block at once; an overflowing length goes to an extra block.
  always_comb begin
    blk_d = blk_q;
    if (xfer_in) begin
      if (!in_last) begin
        blk_d[32*idx +: 32] = in_data;
      end else begin
        for (int w = 0; w < 16; w++) begin
          if (5'(w) == {1'b0, idx}) begin
            blk_d[32*w +: 32] = pad_last_word(in_data, nb);
          end else if (5'(w) > {1'b0, idx}) begin
            blk_d[32*w +: 32] = (5'(w) == marker_idx) ? {PAD_MARKER, 24'h0} : 32'h0;
          end
        end
        if (marker_idx <= 5'd13) begin
          blk_d[32*14 +: 32] = len_fld_sum[63:32];
          blk_d[32*15 +: 32] = len_fld_sum[31:0];
        end
      end
    end else if (xfer_blk && pend_extra) begin
      blk_d = '0;
      if (extra_marker) begin
        blk_d[31:0] = {PAD_MARKER, 24'h0};
      end
      blk_d[32*14 +: 32] = len_fld_q[63:32];
      blk_d[32*15 +: 32] = len_fld_q[31:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ACCUM;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_en       <= 1'b0;
      idx          <= '0;
      mid_msg      <= 1'b0;
      pend_extra   <= 1'b0;
      extra_marker <= 1'b0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      blk_q        <= '0;
    end else begin
      rdy_en <= 1'b1;
      blk_q  <= blk_d;
      if (xfer_in) begin
        idx <= idx + 4'd1;
        if (blk_done) begin
          first_q      <= !mid_msg;
          last_q       <= in_last && (marker_idx <= 5'd13);
          pend_extra   <= in_last && (marker_idx > 5'd13);
          extra_marker <= in_last && (marker_idx == 5'd16);
        end
      end
      if (xfer_blk) begin
        if (pend_extra) begin
          pend_extra <= 1'b0;
          first_q    <= 1'b0;
          last_q     <= 1'b1;
        end else begin
          idx     <= '0;
          mid_msg <= !last_q;
          first_q <= 1'b0;
          last_q  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/sha256_padder.md
Name: sha256_padder

Overview:
Message front-end for the SHA-256 compression core. It accepts a byte-granular message as a stream of 32-bit big-endian words and applies FIPS 180-4 padding: 0x80 marker, zero fill, and a 64-bit bit-length. It emits 512-bit blocks, one at a time, over a valid/ready handshake to the hash core, with first/last block markers so the core knows when to reload H0..H7 and when the digest is final.

Parameters:
LEN_W, 64, width of the internal bit-length counter; bits above LEN_W in the appended 64-bit length field are zero (LEN_W <= 64).

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  input word valid
in_ready  output  1  padder can accept a word
in_data  input  32  message word, big-endian (first byte in [31:24])
in_last  input  1  word is the final message word
in_bytes  input  3  valid bytes in a last word, 1..4, MSB-aligned; ignored when in_last=0
blk_valid  output  1  padded block available
blk_ready  input  1  hash core accepts the block
blk_data  output  512  block; word i at [32*i +: 32]; word 0 is the first message word
blk_first  output  1  block is the first of a message
blk_last  output  1  block is the final block of a message

Behaviour:
- Reset (async, reset_n=0):
  - in_ready=0, blk_valid=0, blk_first=0, blk_last=0, blk_data=0.
  - Word index, bit-length counter and first flag cleared; FSM to ACCUM.
  - in_ready rises one cycle after reset_n deasserts.
- Word transfer: occurs when in_valid && in_ready. Block transfer: occurs when blk_valid && blk_ready.
- ACCUM state:
  - in_ready=1. Each transfer writes word idx and adds 32 to the length (8*in_bytes on a last word). idx increments mod 16.
  - Transfer at idx=15 with in_last=0: go to HOLD; blk_valid=1 next cycle.
  - Transfer with in_last=1: pad in the same cycle.
    - Byte in_bytes of that word gets 0x80 and the remaining bytes are zeroed. If in_bytes=4, the 0x80 goes in word idx+1, byte 0.
    - Words after the marker are zeroed.
    - If the marker word is <= 13: words 14/15 = {len[63:32], len[31:0]}; go to HOLD with pend_extra=0.
    - Otherwise go to HOLD with pend_extra=1 (length goes in an extra block).
- HOLD state:
  - blk_valid=1, in_ready=0. blk_data, blk_first and blk_last stay stable until blk_ready.
  - On handshake with pend_extra=1: build the EXTRA block next cycle. Word 0 = 0x80000000 if the marker overflowed past word 15, else 0. Words 14/15 = length. blk_last=1. Stay in HOLD.
  - On handshake otherwise: return to ACCUM with idx=0. If the block was last, clear the length and set the first flag.
- blk_first=1 on the first block after reset or after a last block. blk_last=1 only on the block carrying the length.
- Latency: a block is presented the cycle after its final word is accepted. There is no input/output overlap (single buffer, throughput 1 block per 17 cycles).
- Length counter wraps at 2^LEN_W silently.
- reset_n asserted mid-message or mid-HOLD: the partial block is discarded immediately; blk_valid drops asynchronously.
- A message of zero bytes is not supported (in_last always carries >= 1 byte).

Optional Feature:
SHA256_PADDER_ERR_EN
- Defined: adds output err (1 bit, sticky, cleared only by reset). err sets the cycle after a transfer with in_last=1 and in_bytes equal to 0 or greater than 4. That word is then treated as in_bytes=4.
- Undefined: no err port. in_bytes outside 1..4 is undefined behaviour.

Decomposition:
- Package sha256_pkg holds:
  - FSM enum (ACCUM, HOLD)
  - SHA256_BLOCK_W=512, SHA256_WORD_W=32, SHA256_LEN_FIELD_W=64
  - PAD_MARKER=8'h80
  - a function that builds the masked last word plus marker from in_data/in_bytes
- One sub-module, sha256_len_ctr: LEN_W bit-length accumulator with clear and add-by-8*n.

Test Plan:
- "abc": in_data=0x61626300, in_last=1, in_bytes=3 -> one block: word0=0x61626380, words1-14=0, word15=0x00000018, blk_first=1, blk_last=1.
- 55-byte message (13 full words + 3 bytes) -> one block: word13 = data|0x80 in byte3, word14=0, word15=0x000001B8.
- 56-byte message (14 full words) -> block A: word14=0x80000000, word15=0, blk_last=0. Block B: words0-13=0, word15=0x000001C0, blk_first=0, blk_last=1.
- 64-byte message -> block A = data, blk_first=1. Block B: word0=0x80000000, word15=0x00000200, blk_last=1.
- Backpressure: hold blk_ready=0 for 20 cycles -> in_ready=0, blk_data stable throughout. Release -> in_ready=1 the next cycle. A second message's first block has blk_first=1.
- Reset mid-block: pull reset_n low after 7 words -> blk_valid=0 immediately. A new "abc" message afterward yields length 0x18, not 7*32+24.
